// File: rtl/seg_scan_decoder_pkg.sv
// Shared seven-segment definitions: gfedcba digit codes, scan FSM states and the
// pattern <-> BCD helpers used by both the display encoder and the scan decoder.
package seg_pkg;

    localparam int unsigned NDIGITS = 8;

    localparam logic [6:0] SEG_0 = 7'b011_1111;
    localparam logic [6:0] SEG_1 = 7'b000_0110;
    localparam logic [6:0] SEG_2 = 7'b101_1011;
    localparam logic [6:0] SEG_3 = 7'b100_1111;
    localparam logic [6:0] SEG_4 = 7'b110_0110;
    localparam logic [6:0] SEG_5 = 7'b110_1101;
    localparam logic [6:0] SEG_6 = 7'b111_1101;
    localparam logic [6:0] SEG_7 = 7'b000_0111;
    localparam logic [6:0] SEG_8 = 7'b111_1111;
    localparam logic [6:0] SEG_9 = 7'b110_1111;
    localparam logic [6:0] BLANK = 7'b000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } scan_state_e;

    typedef struct packed {
        logic       ok;
        logic [3:0] bcd;
    } digit_dec_t;

    function automatic digit_dec_t seg_decode(input logic [6:0] pat);
        digit_dec_t r;
        r.ok = 1'b1;
        case (pat)
            SEG_0:   r.bcd = 4'd0;
            SEG_1:   r.bcd = 4'd1;
            SEG_2:   r.bcd = 4'd2;
            SEG_3:   r.bcd = 4'd3;
            SEG_4:   r.bcd = 4'd4;
            SEG_5:   r.bcd = 4'd5;
            SEG_6:   r.bcd = 4'd6;
            SEG_7:   r.bcd = 4'd7;
            SEG_8:   r.bcd = 4'd8;
            SEG_9:   r.bcd = 4'd9;
            default: begin
                r.ok  = 1'b0;
                r.bcd = 4'hF;
            end
        endcase
        return r;
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return BLANK;
        endcase
    endfunction

    function automatic logic is_onehot(input logic [NDIGITS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic [2:0] onehot_index(input logic [NDIGITS-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Multiplexed seven-segment bus plus the rebuilt-frame outputs of the scan decoder.
interface seg_scan_decoder_if;
    logic [7:0]  seg_in;
    logic [7:0]  an_in;
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  digit_valid;
    logic        frame_valid;
    logic        frame_err;
    logic        stale;

    modport master (
        output seg_in, an_in,
        input  value, dp, digit_valid, frame_valid, frame_err, stale
    );

    modport slave (
        input  seg_in, an_in,
        output value, dp, digit_valid, frame_valid, frame_err, stale
    );
endinterface

// File: rtl/seg_scan_decoder_decode.sv
// Combinational segment-pattern decoder: 7-bit gfedcba -> {ok, BCD}, 4'hF when undecodable.
module seg_digit_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       ok_o,
    output logic [3:0] bcd_o
);
    digit_dec_t dec;

    always_comb begin
        dec   = seg_decode(pattern_i);
        ok_o  = dec.ok;
        bcd_o = dec.bcd;
    end
endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed seven-segment bus and rebuilds the 8-digit BCD frame it shows,
// flagging bad patterns, multi-hot enables and a stalled scan.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE      = 4,
    parameter int unsigned TIMEOUT     = 2**20,
    parameter bit          SEG_ACT_LOW = 1'b0,
    parameter bit          AN_ACT_LOW  = 1'b0
) (
    input logic              clk,
    input logic              reset,
    seg_scan_decoder_if.slave bus
);
    localparam int unsigned CW = $clog2(SETTLE + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE);
    localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE - 1);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    logic [7:0]    seg_q, an_q, an_prev_q;
    scan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, mh_cnt_q, mh_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   value_q, value_d;
    logic [7:0]    dp_q, dp_d, dv_q, dv_d, dv_cap;
    logic          fv_q, fv_d, err_q, err_d, stale_q, stale_d;

    logic          cap, restart, mh_hit;
    logic          an_onehot, an_multi, an_same;
    logic          dec_ok;
    logic [3:0]    dec_bcd;
    logic [2:0]    cap_idx;

    seg_digit_decode u_dec (
        .pattern_i (seg_q[6:0]),
        .ok_o      (dec_ok),
        .bcd_o     (dec_bcd)
    );

    assign an_onehot = is_onehot(an_q);
    assign an_multi  = (an_q != '0) && !an_onehot;
    assign an_same   = (an_q == an_prev_q);
    assign cap_idx   = onehot_index(an_q);

    // HOLD and a broken SETTLE fall through to the IDLE evaluation in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        restart = 1'b0;
        case (state_q)
            ST_IDLE:   restart = 1'b1;
            ST_SETTLE: begin
                if (!an_same) begin
                    restart = 1'b1;
                end else if (cnt_q == SETTLE_M1) begin
                    cap     = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLD:   restart = !an_same;
            default:   restart = 1'b1;
        endcase
        if (restart) begin
            if (an_onehot) begin
                cnt_d = CW'(1);
                if (SETTLE == 1) begin
                    cap     = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_SETTLE;
                end
            end else begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        mh_cnt_d = '0;
        if (an_multi) begin
            if (an_same && (mh_cnt_q != '0))
                mh_cnt_d = (mh_cnt_q == SETTLE_C) ? mh_cnt_q : mh_cnt_q + CW'(1);
            else
                mh_cnt_d = CW'(1);
        end
        mh_hit = an_multi && (mh_cnt_d == SETTLE_C);
    end

    always_comb begin
        value_d = value_q;
        dp_d    = dp_q;
        dv_d    = dv_q;
        fv_d    = 1'b0;
        err_d   = err_q;
        tmo_d   = tmo_q;
        stale_d = stale_q;
        dv_cap  = dv_q | (8'd1 << cap_idx);
        if (cap) begin
            value_d[{cap_idx, 2'b00} +: 4] = dec_bcd;
            dp_d[cap_idx] = seg_q[7];
            tmo_d   = '0;
            stale_d = 1'b0;
            // Completing capture: pulse and restart the frame; only its own error survives.
            if (dv_cap == '1) begin
                fv_d  = 1'b1;
                dv_d  = '0;
                err_d = !dec_ok;
            end else begin
                dv_d  = dv_cap;
                err_d = err_q | !dec_ok;
            end
        end else begin
            if (mh_hit) err_d = 1'b1;
            if (tmo_q != TIMEOUT_C) tmo_d = tmo_q + TW'(1);
            stale_d = (tmo_d == TIMEOUT_C);
            if (stale_d) dv_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q     <= '0;
            an_q      <= '0;
            an_prev_q <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mh_cnt_q  <= '0;
            tmo_q     <= '0;
            value_q   <= '1;
            dp_q      <= '0;
            dv_q      <= '0;
            fv_q      <= 1'b0;
            err_q     <= 1'b0;
            stale_q   <= 1'b0;
        end else begin
            seg_q     <= bus.seg_in ^ {8{SEG_ACT_LOW}};
            an_q      <= bus.an_in ^ {8{AN_ACT_LOW}};
            an_prev_q <= an_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mh_cnt_q  <= mh_cnt_d;
            tmo_q     <= tmo_d;
            value_q   <= value_d;
            dp_q      <= dp_d;
            dv_q      <= dv_d;
            fv_q      <= fv_d;
            err_q     <= err_d;
            stale_q   <= stale_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.dp          = dp_q;
    assign bus.digit_valid = dv_q;
    assign bus.frame_valid = fv_q;
    assign bus.frame_err   = err_q;
    assign bus.stale       = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: drives scan steps and compares against a per-digit
// frame model built from the display rules (digit captured iff one-hot held >= SETTLE).
module tb_seg_scan_decoder;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;
    localparam bit SEG_AL  = 1'b1;
    localparam bit AN_AL   = 1'b0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg_scan_decoder_if bus();

    seg_scan_decoder #(
        .SETTLE      (SETTLE),
        .TIMEOUT     (TIMEOUT),
        .SEG_ACT_LOW (SEG_AL),
        .AN_ACT_LOW  (AN_AL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [6:0] code_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int checks = 0;
    int errors = 0;
    int fv_seen = 0;

    logic [3:0] m_val [8];
    logic [7:0] m_dp, m_dv;
    logic       m_err;
    int         m_frames = 0;
    logic [7:0] prev_an = '0;

    always @(negedge clk) if (bus.frame_valid === 1'b1) fv_seen++;

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int d = 0; d < 10; d++) if (code_tbl[d] == p) return {1'b1, 4'(d)};
        return 5'h0F;
    endfunction

    function automatic logic [31:0] m_value();
        logic [31:0] v;
        for (int i = 0; i < 8; i++) v[i*4 +: 4] = m_val[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_val[i] = 4'hF;
        m_dp = '0; m_dv = '0; m_err = 1'b0; prev_an = '0;
    endtask

    task automatic step(input logic [7:0] an, input logic [6:0] pat, input logic dpv, input int hold);
        logic [4:0] r;
        int d;
        bus.an_in  = AN_AL ? ~an : an;
        bus.seg_in = SEG_AL ? ~{dpv, pat} : {dpv, pat};
        repeat (hold) @(negedge clk);
        prev_an = an;
        if ($countones(an) == 1 && hold >= SETTLE) begin
            d = 0;
            for (int i = 0; i < 8; i++) if (an[i]) d = i;
            r = ref_decode(pat);
            m_val[d] = r[3:0]; m_dp[d] = dpv; m_dv[d] = 1'b1;
            if (!r[4]) m_err = 1'b1;
            if (m_dv == 8'hFF) begin
                m_frames++; m_dv = '0; m_err = !r[4];
            end
        end else if ($countones(an) > 1 && hold >= SETTLE) begin
            m_err = 1'b1;
        end
    endtask

    task automatic blank(input int n);
        step(8'h00, 7'h00, 1'b0, n);
    endtask

    task automatic scan_frame(input logic [31:0] bcd, input int hold);
        for (int i = 0; i < 8; i++) step(8'(1 << i), code_tbl[bcd[i*4 +: 4]], 1'b0, hold);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.an_in = AN_AL ? 8'hFF : 8'h00;
        bus.seg_in = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.value !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_value: got %h expected ffffffff", bus.value); end
        checks++; if (bus.dp !== 8'h00) begin errors++; $display("FAIL reset_dp: got %h expected 00", bus.dp); end
        checks++; if (bus.digit_valid !== 8'h00) begin errors++; $display("FAIL reset_dv: got %h expected 00", bus.digit_valid); end
        checks++; if ({bus.frame_valid, bus.frame_err, bus.stale} !== 3'b000) begin errors++;
            $display("FAIL reset_flags: got %b expected 000", {bus.frame_valid, bus.frame_err, bus.stale}); end
        reset = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_scan();
        int f0 = fv_seen;
        scan_frame(32'h8765_4321, 10);
        blank(3);
        checks++; if (fv_seen - f0 !== 1) begin errors++; $display("FAIL scan_pulses: got %0d expected 1", fv_seen - f0); end
        checks++; if (bus.value !== 32'h8765_4321) begin errors++; $display("FAIL scan_value: got %h expected 87654321", bus.value); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL scan_err: got %b expected 0", bus.frame_err); end
        checks++; if (bus.digit_valid !== 8'h00) begin errors++; $display("FAIL scan_dv: got %h expected 00", bus.digit_valid); end
    endtask

    task automatic test_multihot();
        int f0 = fv_seen;
        step(8'h01, code_tbl[3], 1'b0, 6);
        step(8'h02, code_tbl[4], 1'b1, 6);
        step(8'h03, code_tbl[8], 1'b0, 20);
        blank(3);
        checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL mh_err: got %b expected 1", bus.frame_err); end
        checks++; if (bus.digit_valid !== 8'h03) begin errors++; $display("FAIL mh_dv: got %h expected 03", bus.digit_valid); end
        for (int i = 2; i < 8; i++) step(8'(1 << i), code_tbl[i], 1'b0, 6);
        blank(3);
        checks++; if (bus.frame_err !== m_err) begin errors++; $display("FAIL mh_err_cleared: got %b expected %b", bus.frame_err, m_err); end
        checks++; if (fv_seen - f0 !== 1) begin errors++; $display("FAIL mh_pulses: got %0d expected 1", fv_seen - f0); end
        checks++; if (bus.dp !== m_dp) begin errors++; $display("FAIL mh_dp: got %h expected %h", bus.dp, m_dp); end
    endtask

    task automatic test_short();
        int f0 = fv_seen;
        for (int i = 0; i < 3; i++) step(8'(1 << i), code_tbl[9 - i], 1'b0, 6);
        step(8'h08, code_tbl[6], 1'b0, SETTLE - 1);
        blank(3);
        checks++; if (bus.digit_valid !== 8'h07) begin errors++; $display("FAIL short_dv: got %h expected 07", bus.digit_valid); end
        for (int i = 4; i < 8; i++) step(8'(1 << i), code_tbl[i], 1'b0, 5);
        blank(3);
        checks++; if (bus.digit_valid !== 8'hF7) begin errors++; $display("FAIL short_dv_gap: got %h expected f7", bus.digit_valid); end
        checks++; if (fv_seen !== f0) begin errors++; $display("FAIL short_no_pulse: got %0d expected %0d", fv_seen, f0); end
        step(8'h08, code_tbl[6], 1'b0, SETTLE);
        blank(3);
        checks++; if (fv_seen - f0 !== 1) begin errors++; $display("FAIL short_final_pulse: got %0d expected 1", fv_seen - f0); end
        checks++; if (bus.value !== m_value()) begin errors++; $display("FAIL short_value: got %h expected %h", bus.value, m_value()); end
    endtask

    task automatic test_bad();
        int order [8] = '{0, 1, 2, 3, 4, 6, 7, 5};
        int f0 = fv_seen;
        for (int k = 0; k < 8; k++)
            step(8'(1 << order[k]), (order[k] == 5) ? 7'b1110111 : code_tbl[order[k]], 1'b0, 8);
        blank(3);
        checks++; if (fv_seen - f0 !== 1) begin errors++; $display("FAIL bad_pulses: got %0d expected 1", fv_seen - f0); end
        checks++; if (bus.value[23:20] !== 4'hF) begin errors++; $display("FAIL bad_nibble: got %h expected f", bus.value[23:20]); end
        checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL bad_err: got %b expected 1", bus.frame_err); end
    endtask

    task automatic test_random();
        logic [7:0] an;
        logic [6:0] pat;
        int kind, a, b;
        bit prev_cap;
        for (int r = 0; r < 4; r++) begin
            prev_cap = 1'b1;
            for (int s = 0; s < 12; s++) begin
                kind = int'($urandom_range(0, 99));
                pat = ($urandom_range(0, 9) == 0) ? 7'($urandom) : code_tbl[$urandom_range(0, 9)];
                if (!prev_cap || kind >= 15) begin
                    an = 8'(1 << $urandom_range(0, 7));
                    if (an == prev_an) blank(1);
                    step(an, pat, 1'($urandom), int'($urandom_range(SETTLE, 8)));
                    prev_cap = 1'b1;
                end else if (kind < 8) begin
                    an = 8'(1 << $urandom_range(0, 7));
                    if (an == prev_an) blank(1);
                    step(an, pat, 1'($urandom), int'($urandom_range(1, SETTLE - 1)));
                    prev_cap = 1'b0;
                end else begin
                    a = int'($urandom_range(0, 7));
                    b = (a + 1 + int'($urandom_range(0, 6))) % 8;
                    an = 8'(1 << a) | 8'(1 << b);
                    if (an == prev_an) blank(1);
                    step(an, pat, 1'b0, int'($urandom_range(SETTLE, 6)));
                    prev_cap = 1'b0;
                end
                if ($urandom_range(0, 3) == 0) blank(int'($urandom_range(1, 2)));
            end
            blank(3);
            checks++; if (bus.value !== m_value()) begin errors++; $display("FAIL rnd_value[%0d]: got %h expected %h", r, bus.value, m_value()); end
            checks++; if (bus.dp !== m_dp) begin errors++; $display("FAIL rnd_dp[%0d]: got %h expected %h", r, bus.dp, m_dp); end
            checks++; if (bus.digit_valid !== m_dv) begin errors++; $display("FAIL rnd_dv[%0d]: got %h expected %h", r, bus.digit_valid, m_dv); end
            checks++; if (bus.frame_err !== m_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b expected %b", r, bus.frame_err, m_err); end
            checks++; if (fv_seen !== m_frames) begin errors++; $display("FAIL rnd_frames[%0d]: got %0d expected %0d", r, fv_seen, m_frames); end
            checks++; if (bus.stale !== 1'b0) begin errors++; $display("FAIL rnd_stale[%0d]: got %b expected 0", r, bus.stale); end
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 3; i++) step(8'(1 << i), code_tbl[i + 4], 1'b0, 6);
        blank(3);
        repeat (47) @(negedge clk);
        checks++; if (bus.stale !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b expected 0", bus.stale); end
        checks++; if (bus.digit_valid !== m_dv) begin errors++; $display("FAIL tmo_dv_before: got %h expected %h", bus.digit_valid, m_dv); end
        repeat (30) @(negedge clk);
        m_dv = '0;
        checks++; if (bus.stale !== 1'b1) begin errors++; $display("FAIL tmo_stale: got %b expected 1", bus.stale); end
        checks++; if (bus.digit_valid !== 8'h00) begin errors++; $display("FAIL tmo_dv_cleared: got %h expected 00", bus.digit_valid); end
        checks++; if (bus.value !== m_value()) begin errors++; $display("FAIL tmo_value_kept: got %h expected %h", bus.value, m_value()); end
        step(8'h04, code_tbl[7], 1'b1, 6);
        blank(2);
        checks++; if (bus.stale !== 1'b0) begin errors++; $display("FAIL tmo_recover: got %b expected 0", bus.stale); end
        checks++; if (bus.digit_valid !== 8'h04) begin errors++; $display("FAIL tmo_recover_dv: got %h expected 04", bus.digit_valid); end
    endtask

    task automatic test_reset_mid();
        int f0;
        for (int i = 0; i < 4; i++) step(8'(1 << i), code_tbl[i], 1'b1, 6);
        bus.an_in = AN_AL ? ~8'h10 : 8'h10;
        bus.seg_in = SEG_AL ? ~{1'b0, code_tbl[5]} : {1'b0, code_tbl[5]};
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.value !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mid_value: got %h expected ffffffff", bus.value); end
        checks++; if ({bus.dp, bus.digit_valid} !== 16'h0000) begin errors++;
            $display("FAIL mid_dp_dv: got %h expected 0000", {bus.dp, bus.digit_valid}); end
        checks++; if ({bus.frame_valid, bus.frame_err, bus.stale} !== 3'b000) begin errors++;
            $display("FAIL mid_flags: got %b expected 000", {bus.frame_valid, bus.frame_err, bus.stale}); end
        bus.an_in = AN_AL ? 8'hFF : 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        f0 = fv_seen;
        scan_frame(32'h2468_1357, 6);
        blank(3);
        checks++; if (fv_seen - f0 !== 1) begin errors++; $display("FAIL mid_restart_pulses: got %0d expected 1", fv_seen - f0); end
        checks++; if (bus.value !== 32'h2468_1357) begin errors++; $display("FAIL mid_restart_value: got %h expected 24681357", bus.value); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan();
        test_multihot();
        test_short();
        test_bad();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
